// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory sequencer: each 32-bit load/store becomes two 16-bit async-SRAM phases.
// Optional single-entry read buffer enabled with `MEM_READ_BUFFER_EN.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int WW = SRAM_AW - 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          op_write;
  logic [WW-1:0] w_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic [31:0]   offset;
  logic [WW-1:0] w_in;
  logic          req;
  logic          last;
  logic          hit;
  logic          unused_bits;

  assign offset      = address - 32'(BASE_ADDR);
  assign w_in        = offset[SRAM_AW:2];
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign req         = wr_en | rd_en;
  assign last        = (cnt == 4'(WAIT_CYCLES - 1));

`ifdef MEM_READ_BUFFER_EN
  logic          buf_valid;
  logic [WW-1:0] buf_tag;
  logic [31:0]   buf_data;

  // A hit only counts for a pure read presented in IDLE; wr_en wins when both are set.
  assign hit = (state == IDLE) & rd_en & ~wr_en & buf_valid & (buf_tag == w_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == HIGH && last) begin
      if (!op_write) begin
        buf_valid <= 1'b1;
        buf_tag   <= w_q;
        buf_data  <= {sram_rdata, rdata_q[15:0]};
      end else if (buf_valid && buf_tag == w_q) begin
        buf_data  <= wdata_q;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Handshake: ready=0 freezes the pipeline; an access completes on the edge that ends a ready=1 cycle.
  always_comb begin
    ready = 1'b0;
    rdata = rdata_q;
    case (state)
      IDLE:    ready = hit | ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
`ifdef MEM_READ_BUFFER_EN
    if (hit) rdata = buf_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write   <= 1'b0;
      w_q        <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            state      <= LOW;
            cnt        <= 4'd0;
            op_write   <= wr_en;
            w_q        <= w_in;
            wdata_q    <= wdata;
            sram_addr  <= {w_in, 1'b0};
            sram_wdata <= wr_en ? wdata[15:0] : 16'h0000;
            sram_dq_oe <= wr_en;
            sram_we_n  <= ~wr_en;
            sram_oe_n  <= wr_en;
          end
`ifdef MEM_READ_BUFFER_EN
          else if (hit) begin
            rdata_q <= buf_data;
          end
`endif
        end
        LOW: begin
          if (last) begin
            state      <= HIGH;
            cnt        <= 4'd0;
            sram_addr  <= {w_q, 1'b1};
            sram_wdata <= op_write ? wdata_q[31:16] : 16'h0000;
            if (!op_write) rdata_q[15:0] <= sram_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (last) begin
            state      <= DONE;
            cnt        <= 4'd0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            if (!op_write) rdata_q[31:16] <= sram_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          // The request is still asserted here; the pipeline advances on this edge, so do not restart.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit async SRAM.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int errors = 0;
  int checks = 0;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM model: a halfword write lands only after we_n is held low for two full cycles at one address.
  logic [15:0] mem [0:63] = '{default: 16'h0000};
  logic [17:0] run_addr = '0;
  int          run_len  = 0;
  int          wr_done  = 0;

  assign sram_rdata = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

  always @(negedge clk) begin
    if (!sram_we_n) begin
      if (run_len != 0 && sram_addr == run_addr) run_len = run_len + 1;
      else begin
        run_addr = sram_addr;
        run_len  = 1;
      end
      if (run_len == 2) begin
        mem[sram_addr[5:0]] = sram_wdata;
        wr_done = wr_done + 1;
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drives one request at cycle 0 and checks every cycle through DONE (cycle 5).
  task automatic run_access(input string tag, input logic drv_wr, input logic drv_rd,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_wr, input logic [17:0] exp_lo,
                            input logic [31:0] exp_rdata);
    next_cycle();
    wr_en = drv_wr; rd_en = drv_rd; address = addr; wdata = data;
    sample();
    chk({tag, "_ready_c0"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 2) begin
        address = 32'hFFFF_FFFC;
        wdata   = ~data;
      end
      sample();
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'd0);
      chk($sformatf("%s_we_n_c%0d", tag, c), 32'(sram_we_n), 32'(!exp_wr));
      chk($sformatf("%s_oe_n_c%0d", tag, c), 32'(sram_oe_n), 32'(exp_wr));
      chk($sformatf("%s_dq_oe_c%0d", tag, c), 32'(sram_dq_oe), 32'(exp_wr));
      chk($sformatf("%s_addr_c%0d", tag, c), 32'(sram_addr),
          (c <= 2) ? 32'(exp_lo) : 32'(exp_lo + 18'd1));
      if (exp_wr)
        chk($sformatf("%s_wdata_c%0d", tag, c), 32'(sram_wdata),
            (c <= 2) ? 32'(data[15:0]) : 32'(data[31:16]));
    end
    next_cycle();
    sample();
    chk({tag, "_ready_c5"}, 32'(ready), 32'd1);
    chk({tag, "_we_n_c5"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_oe_n_c5"}, 32'(sram_oe_n), 32'd1);
    chk({tag, "_dq_oe_c5"}, 32'(sram_dq_oe), 32'd0);
    chk({tag, "_addr_c5"}, 32'(sram_addr), 32'd0);
    if (!exp_wr) chk({tag, "_rdata_c5"}, rdata, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; wdata = 32'd0;
    repeat (2) next_cycle();
    sample();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe_n", 32'(sram_oe_n), 32'd1);
    chk("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("idle_ready", 32'(ready), 32'd1);

    // Word 0: halves at SRAM 0/1.
    run_access("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b1, 18'd0, 32'd0);
    chk("wr1024_count", 32'(wr_done), 32'd2);
    chk("wr1024_mem0", 32'(mem[0]), 32'h0000_BEEF);
    chk("wr1024_mem1", 32'(mem[1]), 32'h0000_DEAD);

    run_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 18'd0, 32'hDEAD_BEEF);

    // Back-to-back: write then read of word 1 (SRAM 2/3), request switching right after DONE.
    run_access("wr1028", 1'b1, 1'b0, 32'd1028, 32'hCAFE_F00D, 1'b1, 18'd2, 32'd0);
    run_access("rd1028", 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 18'd2, 32'hCAFE_F00D);
    chk("b2b_count", 32'(wr_done), 32'd4);
    chk("b2b_mem2", 32'(mem[2]), 32'h0000_F00D);
    chk("b2b_mem3", 32'(mem[3]), 32'h0000_CAFE);
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    sample();
    chk("b2b_idle_ready", 32'(ready), 32'd1);
    chk("b2b_idle_rdata", rdata, 32'hCAFE_F00D);

    // Reset during the HIGH phase of a write to word 2 (SRAM 4/5).
    next_cycle();
    wr_en = 1'b1; address = 32'd1032; wdata = 32'h1111_2222;
    repeat (3) next_cycle();
    sample();
    chk("rst_high_we_n", 32'(sram_we_n), 32'd0);
    chk("rst_high_addr", 32'(sram_addr), 32'd5);
    #2;
    rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_addr", 32'(sram_addr), 32'd0);
    repeat (2) next_cycle();
    rst = 1'b0;
    sample();
    chk("rst_after_ready", 32'(ready), 32'd1);
    chk("rst_count", 32'(wr_done), 32'd5);
    chk("rst_mem4", 32'(mem[4]), 32'h0000_2222);
    chk("rst_mem5", 32'(mem[5]), 32'h0000_0000);

    run_access("rd1032", 1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 18'd4, 32'h0000_2222);

    // Both strobes high is a write: word 3 at SRAM 6/7.
    run_access("both1036", 1'b1, 1'b1, 32'd1036, 32'hA5A5_5A5A, 1'b1, 18'd6, 32'd0);
    chk("both_count", 32'(wr_done), 32'd7);
    chk("both_mem6", 32'(mem[6]), 32'h0000_5A5A);
    chk("both_mem7", 32'(mem[7]), 32'h0000_A5A5);
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    sample();
    chk("hold_ready", 32'(ready), 32'd1);
    chk("hold_rdata", rdata, 32'h0000_2222);

`ifdef MEM_READ_BUFFER_EN
    run_access("buf_fill", 1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 18'd0, 32'hDEAD_BEEF);
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024;
    sample();
    chk("buf_hit_ready", 32'(ready), 32'd1);
    chk("buf_hit_rdata", rdata, 32'hDEAD_BEEF);
    chk("buf_hit_oe_n", 32'(sram_oe_n), 32'd1);
    run_access("buf_wr", 1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1'b1, 18'd0, 32'd0);
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024;
    sample();
    chk("buf_wt_ready", 32'(ready), 32'd1);
    chk("buf_wt_rdata", rdata, 32'h1234_5678);
    chk("buf_wt_oe_n", 32'(sram_oe_n), 32'd1);
    next_cycle();
    rd_en = 1'b0;
    sample();
    chk("buf_idle_ready", 32'(ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
